mpf_vtp_mmio_rsp_merge: RTL and testbench

- Sits directly downstream of the VTP MMIO CSR service's read-response FIFO.
- Merges two sources into the single host MMIO read-response channel:
  - VTP CSR read responses (FIFO interface with dequeue).
  - AFU MMIO read responses (single-cycle pulses, no backpressure).
- Buffers AFU responses internally, arbitrates between the two sources, and drives a registered output with a ready/valid handshake.
- Provides an overflow error flag and per-source response counters for debug CSRs.

---
 rtl/mpf_vtp_mmio_rsp_merge.sv | 69 ++++++
 tb/tb_mpf_vtp_mmio_rsp_merge.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mpf_vtp_mmio_rsp_merge.sv
// mpf_vtp_mmio_rsp_merge: merges VTP CSR and buffered AFU MMIO read responses onto one registered host channel
module mpf_vtp_mmio_rsp_merge #(
  parameter int TID_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int AFU_FIFO_ENTRIES = 16,
  parameter int FAIR_ARB = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vtp_rsp_valid,
  input  logic [TID_WIDTH-1:0]  vtp_rsp_tid,
  input  logic [DATA_WIDTH-1:0] vtp_rsp_data,
  output logic                  vtp_rsp_deq,
  input  logic                  afu_rsp_valid,
  input  logic [TID_WIDTH-1:0]  afu_rsp_tid,
  input  logic [DATA_WIDTH-1:0] afu_rsp_data,
  output logic                  afu_almost_full,
  output logic                  host_rsp_valid,
  output logic [TID_WIDTH-1:0]  host_rsp_tid,
  output logic [DATA_WIDTH-1:0] host_rsp_data,
  input  logic                  host_rsp_ready,
  output logic                  afu_overflow,
  output logic [15:0]           vtp_rsp_cnt,
  output logic [15:0]           afu_rsp_cnt
);
  localparam int AW = $clog2(AFU_FIFO_ENTRIES);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(AFU_FIFO_ENTRIES);
  localparam logic [CW-1:0] ALMOST = CW'(AFU_FIFO_ENTRIES - 2);
  logic [TID_WIDTH+DATA_WIDTH-1:0] mem [AFU_FIFO_ENTRIES];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic last_afu, load, afu_ne, full, grant_afu, grant_vtp, push;
  assign afu_ne = cnt != '0;
  assign full = cnt == DEPTH;
  assign load = !host_rsp_valid || host_rsp_ready;
  // With both sources waiting, fair mode hands the grant to whichever source did not win last
  assign grant_afu = !reset && load && afu_ne && (!vtp_rsp_valid || FAIR_ARB == 0 || !last_afu);
  assign grant_vtp = !reset && load && vtp_rsp_valid && !grant_afu;
  assign vtp_rsp_deq = grant_vtp;
  assign push = afu_rsp_valid && (!full || grant_afu);
  assign afu_almost_full = cnt >= ALMOST;
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {afu_rsp_tid, afu_rsp_data};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
      last_afu <= 1'b1;
      afu_overflow <= 1'b0;
      host_rsp_valid <= 1'b0;
      host_rsp_tid <= '0;
      host_rsp_data <= '0;
      vtp_rsp_cnt <= '0;
      afu_rsp_cnt <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (grant_afu) rptr <= rptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(grant_afu);
      if (afu_rsp_valid && !push) afu_overflow <= 1'b1;
      if (load) host_rsp_valid <= grant_afu || grant_vtp;
      if (grant_afu) {host_rsp_tid, host_rsp_data} <= mem[rptr];
      else if (grant_vtp) {host_rsp_tid, host_rsp_data} <= {vtp_rsp_tid, vtp_rsp_data};
      if (grant_afu || grant_vtp) last_afu <= grant_afu;
      if (grant_vtp) vtp_rsp_cnt <= vtp_rsp_cnt + 16'd1;
      if (grant_afu) afu_rsp_cnt <= afu_rsp_cnt + 16'd1;
    end
endmodule

// File: tb/tb_mpf_vtp_mmio_rsp_merge.sv
// tb_mpf_vtp_mmio_rsp_merge: directed checks of the response merge with default parameters
module tb_mpf_vtp_mmio_rsp_merge;
  logic clk = 0, reset;
  logic vtp_rsp_valid, vtp_rsp_deq, afu_rsp_valid, afu_almost_full;
  logic host_rsp_valid, host_rsp_ready, afu_overflow;
  logic [8:0] vtp_rsp_tid, afu_rsp_tid, host_rsp_tid;
  logic [63:0] vtp_rsp_data, afu_rsp_data, host_rsp_data;
  logic [15:0] vtp_rsp_cnt, afu_rsp_cnt;
  int tests = 0, fails = 0, vi;
  logic d;
  logic [8:0] ct_tid [8] = '{9'h10, 9'h20, 9'h11, 9'h21, 9'h12, 9'h22, 9'h13, 9'h23};
  logic [8:0] bp_tid [8] = '{9'h40, 9'h31, 9'h41, 9'h32, 9'h42, 9'h43, 9'h44, 9'h45};

  mpf_vtp_mmio_rsp_merge dut (
    .clk(clk), .reset(reset),
    .vtp_rsp_valid(vtp_rsp_valid), .vtp_rsp_tid(vtp_rsp_tid), .vtp_rsp_data(vtp_rsp_data),
    .vtp_rsp_deq(vtp_rsp_deq),
    .afu_rsp_valid(afu_rsp_valid), .afu_rsp_tid(afu_rsp_tid), .afu_rsp_data(afu_rsp_data),
    .afu_almost_full(afu_almost_full),
    .host_rsp_valid(host_rsp_valid), .host_rsp_tid(host_rsp_tid), .host_rsp_data(host_rsp_data),
    .host_rsp_ready(host_rsp_ready), .afu_overflow(afu_overflow),
    .vtp_rsp_cnt(vtp_rsp_cnt), .afu_rsp_cnt(afu_rsp_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    tests++;
    assert (obs === req) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic vtp(input logic v, input logic [8:0] t);
    vtp_rsp_valid = v;
    vtp_rsp_tid = t;
    vtp_rsp_data = 64'hD000_0000 + 64'(t);
  endtask

  task automatic afu(input logic v, input logic [8:0] t);
    afu_rsp_valid = v;
    afu_rsp_tid = t;
    afu_rsp_data = 64'hD000_0000 + 64'(t);
  endtask

  task automatic chk_out(input string tag, input logic [8:0] t);
    chk({tag, "_valid"}, host_rsp_valid, 1'b1);
    chk({tag, "_tid"}, host_rsp_tid, t);
    chk({tag, "_data"}, host_rsp_data, 64'hD000_0000 + 64'(t));
  endtask

  initial begin
    reset = 1;
    host_rsp_ready = 1;
    vtp(1, 9'h1FF);
    afu(0, 0);
    step;
    chk("rst_valid", host_rsp_valid, 0);
    chk("rst_deq", vtp_rsp_deq, 0);
    chk("rst_vcnt", vtp_rsp_cnt, 0);
    chk("rst_acnt", afu_rsp_cnt, 0);
    chk("rst_ovf", afu_overflow, 0);
    chk("rst_af", afu_almost_full, 0);
    vtp(0, 0);
    reset = 0;
    step;
    // VTP only
    vtp_rsp_valid = 1;
    vtp_rsp_tid = 9'h05;
    vtp_rsp_data = 64'h1234;
    #1;
    chk("vtp_deq", vtp_rsp_deq, 1);
    step;
    vtp(0, 0);
    chk("vtp_valid", host_rsp_valid, 1);
    chk("vtp_tid", host_rsp_tid, 9'h05);
    chk("vtp_data", host_rsp_data, 64'h1234);
    chk("vtp_cnt", vtp_rsp_cnt, 1);
    step;
    chk("vtp_idle", host_rsp_valid, 0);
    // AFU only: visible two cycles after the pulse
    afu_rsp_valid = 1;
    afu_rsp_tid = 9'h1A;
    afu_rsp_data = 64'hDEADBEEF;
    step;
    afu(0, 0);
    chk("afu_lat1", host_rsp_valid, 0);
    step;
    chk("afu_valid", host_rsp_valid, 1);
    chk("afu_tid", host_rsp_tid, 9'h1A);
    chk("afu_data", host_rsp_data, 64'hDEADBEEF);
    chk("afu_cnt", afu_rsp_cnt, 1);
    step;
    chk("afu_idle", host_rsp_valid, 0);
    // Contention with fair arbitration
    vi = 0;
    for (int c = 0; c < 8; c++) begin
      vtp(vi < 4, 9'h10 + 9'(vi));
      afu(c < 4, 9'h20 + 9'(c));
      #1;
      d = vtp_rsp_deq;
      chk("ct_deq", d, c % 2 == 0);
      step;
      if (d) vi++;
      chk_out("ct", ct_tid[c]);
    end
    vtp(0, 0);
    afu(0, 0);
    step;
    chk("ct_idle", host_rsp_valid, 0);
    chk("ct_vcnt", vtp_rsp_cnt, 5);
    chk("ct_acnt", afu_rsp_cnt, 5);
    // Backpressure: 10 stalled cycles, then drain
    vi = 0;
    for (int c = 0; c < 18; c++) begin
      host_rsp_ready = c >= 10;
      vtp(vi < 3, 9'h30 + 9'(vi));
      afu(c < 6, 9'h40 + 9'(c));
      #1;
      d = vtp_rsp_deq;
      chk("bp_deq", d, c == 0 || c == 11 || c == 13);
      step;
      if (d) vi++;
      chk_out("bp", c < 10 ? 9'h30 : bp_tid[c-10]);
    end
    vtp(0, 0);
    afu(0, 0);
    step;
    chk("bp_idle", host_rsp_valid, 0);
    chk("bp_vcnt", vtp_rsp_cnt, 8);
    chk("bp_acnt", afu_rsp_cnt, 11);
    // Overflow: 18 pulses into a stalled output
    host_rsp_ready = 0;
    for (int c = 0; c < 18; c++) begin
      afu(1, 9'h50 + 9'(c));
      step;
      chk("of_valid", host_rsp_valid, c >= 1);
      chk("of_af", afu_almost_full, c >= 14);
      chk("of_ovf", afu_overflow, c >= 17);
    end
    chk("of_hold_tid", host_rsp_tid, 9'h50);
    afu(0, 0);
    host_rsp_ready = 1;
    for (int j = 0; j < 16; j++) begin
      step;
      chk_out("of_drain", 9'h51 + 9'(j));
      chk("of_ovf_sticky", afu_overflow, 1);
    end
    step;
    chk("of_idle", host_rsp_valid, 0);
    chk("of_af_clear", afu_almost_full, 0);
    chk("of_acnt", afu_rsp_cnt, 28);
    // Reset with 5 buffered AFU responses and a valid output
    host_rsp_ready = 0;
    for (int c = 0; c < 6; c++) begin
      afu(1, 9'h70 + 9'(c));
      step;
    end
    afu(0, 0);
    chk_out("mr_pre", 9'h70);
    vtp(1, 9'h1FF);
    reset = 1;
    #1;
    chk("mr_valid", host_rsp_valid, 0);
    chk("mr_deq", vtp_rsp_deq, 0);
    chk("mr_vcnt", vtp_rsp_cnt, 0);
    chk("mr_acnt", afu_rsp_cnt, 0);
    chk("mr_ovf", afu_overflow, 0);
    step;
    reset = 0;
    vtp(0, 0);
    host_rsp_ready = 1;
    step;
    chk("mr_empty", host_rsp_valid, 0);
    afu(1, 9'h80);
    step;
    afu(0, 0);
    chk("mr_lat", host_rsp_valid, 0);
    vtp(1, 9'h90);
    #1;
    chk("mr_tie_deq", vtp_rsp_deq, 1);
    step;
    vtp(0, 0);
    chk_out("mr_first", 9'h90);
    step;
    chk_out("mr_second", 9'h80);
    chk("mr_vcnt2", vtp_rsp_cnt, 1);
    chk("mr_acnt2", afu_rsp_cnt, 1);
    step;
    chk("mr_idle", host_rsp_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
